// File: rtl/x_input_loader.sv
// Frame loader for the X operand stream: fills a NUM_KEYS-entry buffer after start_in,
// then serves registered random-access reads until the core releases the buffer.
module x_input_loader #(
  parameter int DATA_W   = 7,
  parameter int NUM_KEYS = 64,
  parameter int ADDR_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_in,
  input  logic              valid_input,
  input  logic [DATA_W-1:0] X_load,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              release_in,
  output logic              busy,
  output logic              load_done,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   wr_count,
  output logic              drop_err
);

  typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

  localparam logic [ADDR_W:0]   KEYS_W   = (ADDR_W+1)'(NUM_KEYS);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NUM_KEYS-1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     wr_count_q, wr_count_d;
  logic                busy_q, busy_d;
  logic                load_done_q, load_done_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                drop_err_q, drop_err_d;
  logic                wr_en;

  logic [DATA_W-1:0]   mem [NUM_KEYS];

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    wr_count_d  = wr_count_q;
    drop_err_d  = drop_err_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    wr_en       = 1'b0;

    // Any input presented while not loading is lost, including the start cycle itself.
    if (valid_input && (state_q != LOAD)) drop_err_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (start_in) begin
          state_d    = LOAD;
          wr_ptr_d   = '0;
          wr_count_d = '0;
        end
      end
      LOAD: begin
        if (valid_input) begin
          wr_en = 1'b1;
          if (wr_count_q != KEYS_W) wr_count_d = wr_count_q + CNT_ONE;
          // Pointer parks on the last slot instead of wrapping.
          if (wr_ptr_q == LAST_PTR) state_d = READY;
          else                      wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
      end
      READY: begin
        if (rd_en) begin
          rd_valid_d = 1'b1;
          rd_data_d  = ({1'b0, rd_addr} < KEYS_W) ? mem[rd_addr] : '0;
        end
        if (release_in) begin
          state_d    = IDLE;
          wr_count_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d      = (state_d == LOAD);
    load_done_d = (state_d == READY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      wr_count_q  <= '0;
      busy_q      <= 1'b0;
      load_done_q <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      drop_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_count_q  <= wr_count_d;
      busy_q      <= busy_d;
      load_done_q <= load_done_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      drop_err_q  <= drop_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= X_load;
  end

  assign busy      = busy_q;
  assign load_done = load_done_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign wr_count  = wr_count_q;
  assign drop_err  = drop_err_q;

endmodule

// File: tb/tb_x_input_loader.sv
// Directed bench for x_input_loader: gapped, nominal, drop, release and async-reset frames.
module tb_x_input_loader;

  localparam int DATA_W   = 7;
  localparam int NUM_KEYS = 64;
  localparam int ADDR_W   = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_in;
  logic              valid_input;
  logic [DATA_W-1:0] X_load;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              release_in;
  logic              busy;
  logic              load_done;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [ADDR_W:0]   wr_count;
  logic              drop_err;

  int errors = 0;
  int checks = 0;
  logic [DATA_W-1:0] exp_mem [NUM_KEYS];

  x_input_loader #(.DATA_W(DATA_W), .NUM_KEYS(NUM_KEYS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start_in(start_in), .valid_input(valid_input),
    .X_load(X_load), .rd_en(rd_en), .rd_addr(rd_addr), .release_in(release_in),
    .busy(busy), .load_done(load_done), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_count(wr_count), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start_in = 1'b0; valid_input = 1'b0; X_load = '0;
    rd_en = 1'b0; rd_addr = '0; release_in = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_load_done"}, load_done, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_wr_count"}, wr_count, 0);
    chk({tag, "_drop_err"}, drop_err, 0);
  endtask

  task automatic start_frame();
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_wr_count", wr_count, 0);
  endtask

  task automatic read_all();
    for (int a = 0; a < NUM_KEYS; a++) begin
      rd_en = 1'b1; rd_addr = ADDR_W'(a);
      tick();
      chk("rd_valid", rd_valid, 1);
      chk($sformatf("rd_data[%0d]", a), rd_data, exp_mem[a]);
    end
    rd_en = 1'b0;
    tick();
    chk("rd_valid_after", rd_valid, 0);
  endtask

  task automatic release_frame();
    release_in = 1'b1;
    tick();
    release_in = 1'b0;
    chk("rel_load_done", load_done, 0);
    chk("rel_wr_count", wr_count, 0);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b0;
    tick();

    // Gapped frame: one write every third cycle.
    start_frame();
    for (int i = 0; i < NUM_KEYS; i++) begin
      valid_input = 1'b1; X_load = DATA_W'(7'h7F - i); exp_mem[i] = DATA_W'(7'h7F - i);
      tick();
      valid_input = 1'b0;
      chk("gap_wr_count", wr_count, i + 1);
      if (i < NUM_KEYS - 1) begin
        tick(); tick();
        chk("gap_hold_count", wr_count, i + 1);
        chk("gap_busy", busy, 1);
      end
    end
    chk("gap_load_done", load_done, 1);
    chk("gap_busy_end", busy, 0);
    chk("gap_drop_err", drop_err, 0);
    read_all();
    release_frame();

    // Drops in IDLE and on the start cycle.
    valid_input = 1'b1; X_load = 7'h55;
    tick();
    chk("drop_idle", drop_err, 1);
    chk("drop_idle_busy", busy, 0);
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    chk("drop_start_busy", busy, 1);
    chk("drop_start_count", wr_count, 0);
    chk("drop_start_err", drop_err, 1);

    // Nominal frame with a start pulse after 10 writes.
    for (int i = 0; i < NUM_KEYS; i++) begin
      valid_input = 1'b1; X_load = DATA_W'(i); exp_mem[i] = DATA_W'(i);
      start_in = (i == 10);
      tick();
      if (i == 10 || i == 11) chk("ign_start_count", wr_count, i + 1);
      if (i == NUM_KEYS - 2) chk("nom_not_done", load_done, 0);
    end
    start_in = 1'b0;
    chk("nom_load_done", load_done, 1);
    chk("nom_busy", busy, 0);
    chk("nom_wr_count", wr_count, NUM_KEYS);

    // Input and start in READY: both ignored.
    valid_input = 1'b1; X_load = 7'h55; start_in = 1'b1;
    tick();
    valid_input = 1'b0; start_in = 1'b0;
    chk("ready_ign_done", load_done, 1);
    chk("ready_ign_busy", busy, 0);
    chk("ready_ign_count", wr_count, NUM_KEYS);
    chk("ready_drop_err", drop_err, 1);
    read_all();

    // Read together with release.
    rd_en = 1'b1; rd_addr = 6'd5; release_in = 1'b1;
    tick();
    release_in = 1'b0; rd_addr = 6'd7;
    chk("relrd_valid", rd_valid, 1);
    chk("relrd_data", rd_data, 5);
    chk("relrd_load_done", load_done, 0);
    tick();
    rd_en = 1'b0;
    chk("post_rel_valid", rd_valid, 0);
    chk("post_rel_data_hold", rd_data, 5);
    chk("sticky_drop_err", drop_err, 1);

    // Partial frame abandoned by async reset between edges.
    start_frame();
    for (int i = 0; i < 30; i++) begin
      valid_input = 1'b1; X_load = DATA_W'(i);
      tick();
    end
    valid_input = 1'b0;
    chk("partial_count", wr_count, 30);
    #2 rst = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    rst = 1'b0;
    tick();
    chk("post_rst_busy", busy, 0);

    // Fresh full frame after reset.
    start_frame();
    for (int i = 0; i < NUM_KEYS; i++) begin
      valid_input = 1'b1; X_load = DATA_W'(i) ^ 7'h2A; exp_mem[i] = DATA_W'(i) ^ 7'h2A;
      tick();
    end
    valid_input = 1'b0;
    chk("f3_load_done", load_done, 1);
    chk("f3_wr_count", wr_count, NUM_KEYS);
    read_all();
    release_frame();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/x_input_loader.md
# x_input_loader

Upstream input stage for `top_top`. It accepts the 7-bit X operand stream (`X_load` qualified by `valid_input`) after a `start_in` trigger and writes NUM_KEYS entries into an internal buffer. When the buffer is full it exposes a registered random-access read port to the compute core. The core releases the buffer when it has finished, and the loader then returns to idle for the next frame.

## Interface
Parameters:
- DATA_W, 7, width of one X entry
- NUM_KEYS, 64, entries per frame
- ADDR_W, 6, read/write address width; requires 2^ADDR_W >= NUM_KEYS

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start_in  in  1  begin a frame; sampled only in IDLE
- valid_input  in  1  X_load qualifier
- X_load  in  DATA_W  input entry
- rd_en  in  1  core read request
- rd_addr  in  ADDR_W  core read address
- release_in  in  1  core finished with buffer
- busy  out  1  high in LOAD
- load_done  out  1  high in READY
- rd_data  out  DATA_W  registered read data
- rd_valid  out  1  rd_data qualifier
- wr_count  out  ADDR_W+1  entries written this frame
- drop_err  out  1  sticky: input was discarded

## Operation
- Storage: NUM_KEYS x DATA_W register array. The array is not reset, and its contents are unreadable outside READY.
- FSM states: IDLE, LOAD, READY.
  - IDLE -> LOAD on start_in. wr_ptr and wr_count are cleared on entry.
  - LOAD:
    - On valid_input: mem[wr_ptr] <= X_load, wr_ptr++, wr_count++.
    - On the write of entry NUM_KEYS-1: -> READY.
  - READY -> IDLE on release_in. wr_count is cleared on exit.
- start_in in LOAD or READY: ignored. It does not restart the frame.
- valid_input outside LOAD: data discarded and drop_err set. This includes valid_input in the same cycle as the start_in that leaves IDLE.
- drop_err clears only on rst.
- Reads are serviced only in READY:
  - rd_en=1 gives rd_data <= mem[rd_addr] and rd_valid=1 on the next cycle.
  - rd_addr >= NUM_KEYS returns 0 with rd_valid=1.
- rd_en outside READY: rd_valid=0 next cycle, rd_data holds its value.
- release_in and rd_en in the same READY cycle: the read is still serviced (rd_valid=1 next cycle) and the state goes to IDLE.
- release_in outside READY: ignored.
- Width rule: wr_count saturates at NUM_KEYS. wr_ptr never wraps within a frame.

## Timing
- Reset values: busy=0, load_done=0, rd_data=0, rd_valid=0, wr_count=0, drop_err=0. State is IDLE and wr_ptr=0.
- Reset mid-LOAD or mid-READY: immediate return to the reset values. A partial frame is abandoned.
- Start: start_in high at edge n -> busy=1 after edge n.
- Load: one entry per cycle at full rate; gaps in valid_input are allowed.
- Completion: the write of the last entry at edge m -> load_done=1 and busy=0 after edge m. wr_count=NUM_KEYS after the same edge.
- Back-to-back load: the minimum time from start_in to load_done is NUM_KEYS+1 edges.
- Read latency: 1 cycle. rd_en is accepted every cycle, giving full-throughput reads.
- Release: release_in at edge r -> load_done=0 after edge r. A new start_in is accepted at edge r+1 or later.

## Test plan
- Nominal frame:
  - Stimulus: start_in pulse, then 64 consecutive valid_input with X_load=i[6:0] for i=0..63, then read addresses 0..63 back-to-back.
  - Required: load_done rises 1 cycle after the 64th write, wr_count=64, rd_data=addr on each cycle after rd_en, rd_valid continuous for 64 cycles.
- Gapped input:
  - Stimulus: valid_input asserted every third cycle with X_load=7'h7F-i.
  - Required: wr_count increments only on valid cycles, all 64 values read back correctly, drop_err=0.
- Drops:
  - Stimulus: valid_input with X_load=7'h55 in IDLE; start_in and valid_input in the same cycle; valid_input in READY.
  - Required: each is discarded, drop_err=1 and it stays 1, mem[0] is unaffected.
- Ignored controls:
  - Stimulus: start_in pulses mid-LOAD after 10 writes and again in READY.
  - Required: wr_count continues 11, 12, ...; no restart; load_done stays 1.
- Release with concurrent read:
  - Stimulus: rd_en with rd_addr=5 together with release_in.
  - Required: rd_valid=1 with rd_data=5 next cycle, load_done=0, a subsequent rd_en gives rd_valid=0, and a second full frame loads correctly.
- Async reset:
  - Stimulus: rst asserted mid-clock after 30 writes.
  - Required: all outputs return to their reset values immediately without a clock edge, state is IDLE, and a new frame completes normally.
